// File: rtl/iob_sync_asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: width arithmetic used to derive
// ratios and address widths from the write/read data widths.
package iob_sync_asym_fifo_pkg;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Address bits lost on the wide side: log2 of the width ratio.
  function automatic int ratio_log2(input int wide_w, input int narrow_w);
    return $clog2(wide_w / narrow_w);
  endfunction

endpackage

// File: rtl/iob_sync_asym_fifo_ptr.sv
// Wrapping pointer: advances by STEP on each enable, modulo 2**W.
module iob_fifo_ptr #(
  parameter int W    = 4,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer; natural overflow of the W-bit add provides the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + STEP_W;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO controller with independent write and read widths.
// Storage lives in an external asymmetric two-port RAM; this block owns the
// pointers, the occupancy level (in units of the narrower word) and the flags.
module iob_sync_asym_fifo
  import iob_sync_asym_fifo_pkg::*;
#(
  parameter  int W_DATA_W = 32,
  parameter  int R_DATA_W = 8,
  parameter  int ADDR_W   = 6,
  localparam int MIN_W    = min_i(W_DATA_W, R_DATA_W),
  localparam int W_RATIO  = W_DATA_W / MIN_W,
  localparam int R_RATIO  = R_DATA_W / MIN_W,
  localparam int W_ADDR_W = ADDR_W - ratio_log2(W_DATA_W, MIN_W),
  localparam int R_ADDR_W = ADDR_W - ratio_log2(R_DATA_W, MIN_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                ext_mem_w_en,
  output logic [W_ADDR_W-1:0] ext_mem_w_addr,
  output logic [W_DATA_W-1:0] ext_mem_w_data,
  output logic                ext_mem_r_en,
  output logic [R_ADDR_W-1:0] ext_mem_r_addr,
  input  logic [R_DATA_W-1:0] ext_mem_r_data
);

  localparam logic [ADDR_W:0] W_STEP   = (ADDR_W + 1)'(W_RATIO);
  localparam logic [ADDR_W:0] R_STEP   = (ADDR_W + 1)'(R_RATIO);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'((2 ** ADDR_W) - W_RATIO);

  logic                w_acc;
  logic                r_acc;
  logic [ADDR_W:0]     level_q, level_d;
  logic                w_full_q, w_full_d;
  logic                r_empty_q, r_empty_d;
  logic                r_acc_q;
  logic [R_DATA_W-1:0] r_hold_q;

  assign w_acc = w_en & ~w_full_q;
  assign r_acc = r_en & ~r_empty_q;

  iob_fifo_ptr #(
    .W    (W_ADDR_W),
    .STEP (1)
  ) u_w_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (w_acc),
    .ptr_o (ext_mem_w_addr)
  );

  iob_fifo_ptr #(
    .W    (R_ADDR_W),
    .STEP (1)
  ) u_r_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (r_acc),
    .ptr_o (ext_mem_r_addr)
  );

  // Next level and flags; flags are registered from the next level so they
  // are glitch-free and line up with level_q in the following cycle.
  always_comb begin
    level_d = level_q;
    if (w_acc) level_d = level_d + W_STEP;
    if (r_acc) level_d = level_d - R_STEP;
    w_full_d  = (level_d > FULL_THR);
    r_empty_d = (level_d < R_STEP);
  end

  // Level, flag and read-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
      r_acc_q   <= 1'b0;
      r_hold_q  <= '0;
    end else begin
      level_q   <= level_d;
      w_full_q  <= w_full_d;
      r_empty_q <= r_empty_d;
      r_acc_q   <= r_acc;
      if (r_acc_q) r_hold_q <= ext_mem_r_data;
    end
  end

  // The RAM output is only trusted in the cycle after an accepted read;
  // otherwise the last delivered word is held regardless of RAM behaviour.
  always_comb begin
    r_data = r_hold_q;
    if (r_acc_q) r_data = ext_mem_r_data;
  end

  assign w_full         = w_full_q;
  assign r_empty        = r_empty_q;
  assign level          = level_q;
  assign ext_mem_w_en   = w_acc;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = r_acc;

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// Bench for the asymmetric FIFO: a 32->8 instance driven by directed and
// random traffic against a byte-queue model, and an 8->32 instance checked
// for read-side empty threshold and sub-word ordering.
module tb_iob_sync_asym_fifo;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: 32-bit write, 8-bit read ----------------
  logic        w_en_a, r_en_a;
  logic [31:0] w_data_a;
  logic        w_full_a, r_empty_a;
  logic [7:0]  r_data_a;
  logic [6:0]  level_a;
  logic        mw_en_a, mr_en_a;
  logic [3:0]  mw_addr_a;
  logic [5:0]  mr_addr_a;
  logic [31:0] mw_data_a;
  logic [7:0]  mr_data_a;

  iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(6)) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_en           (w_en_a),
    .w_data         (w_data_a),
    .w_full         (w_full_a),
    .r_en           (r_en_a),
    .r_data         (r_data_a),
    .r_empty        (r_empty_a),
    .level          (level_a),
    .ext_mem_w_en   (mw_en_a),
    .ext_mem_w_addr (mw_addr_a),
    .ext_mem_w_data (mw_data_a),
    .ext_mem_r_en   (mr_en_a),
    .ext_mem_r_addr (mr_addr_a),
    .ext_mem_r_data (mr_data_a)
  );

  // Asymmetric RAM model, byte-organised, little-endian sub-words.
  logic [7:0] mem_a [64];
  always @(posedge clk) begin
    if (mr_en_a) mr_data_a <= mem_a[mr_addr_a];
    if (mw_en_a)
      for (int k = 0; k < 4; k++) mem_a[int'(mw_addr_a) * 4 + k] <= mw_data_a[k*8 +: 8];
  end

  // ---------------- instance B: 8-bit write, 32-bit read ----------------
  logic        w_en_b, r_en_b;
  logic [7:0]  w_data_b;
  logic        w_full_b, r_empty_b;
  logic [31:0] r_data_b;
  logic [6:0]  level_b;
  logic        mw_en_b, mr_en_b;
  logic [5:0]  mw_addr_b;
  logic [3:0]  mr_addr_b;
  logic [7:0]  mw_data_b;
  logic [31:0] mr_data_b;

  iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(6)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_en           (w_en_b),
    .w_data         (w_data_b),
    .w_full         (w_full_b),
    .r_en           (r_en_b),
    .r_data         (r_data_b),
    .r_empty        (r_empty_b),
    .level          (level_b),
    .ext_mem_w_en   (mw_en_b),
    .ext_mem_w_addr (mw_addr_b),
    .ext_mem_w_data (mw_data_b),
    .ext_mem_r_en   (mr_en_b),
    .ext_mem_r_addr (mr_addr_b),
    .ext_mem_r_data (mr_data_b)
  );

  logic [7:0] mem_b [64];
  always @(posedge clk) begin
    if (mr_en_b)
      for (int k = 0; k < 4; k++) mr_data_b[k*8 +: 8] <= mem_b[int'(mr_addr_b) * 4 + k];
    if (mw_en_b) mem_b[mw_addr_b] <= mw_data_b;
  end

  // ---------------- reference model for instance A ----------------
  logic [7:0] q_a [$];
  int         wptr_m, rptr_m;
  logic [7:0] last_rd_m;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on instance A, checked against the byte queue.
  task automatic step_a(input logic we, input logic [31:0] wd, input logic re);
    logic       wacc, racc;
    logic [7:0] exp_rd;
    exp_rd = '0;
    @(negedge clk);
    w_en_a = we; w_data_a = wd; r_en_a = re;
    #1;
    wacc = we && (q_a.size() <= 64 - 4);
    racc = re && (q_a.size() >= 1);
    chk("a_mem_w_en", {31'd0, mw_en_a}, {31'd0, wacc});
    chk("a_mem_r_en", {31'd0, mr_en_a}, {31'd0, racc});
    if (wacc) begin
      chk("a_mem_w_addr", {28'd0, mw_addr_a}, wptr_m % 16);
      chk("a_mem_w_data", mw_data_a, wd);
    end
    if (racc) chk("a_mem_r_addr", {26'd0, mr_addr_a}, rptr_m % 64);
    if (racc) begin
      exp_rd = q_a.pop_front();
      rptr_m++;
    end
    if (wacc) begin
      for (int k = 0; k < 4; k++) q_a.push_back(wd[k*8 +: 8]);
      wptr_m++;
    end
    @(posedge clk);
    #1;
    if (racc) last_rd_m = exp_rd;
    chk("a_r_data",  {24'd0, r_data_a},  {24'd0, last_rd_m});
    chk("a_level",   {25'd0, level_a},   q_a.size());
    chk("a_w_full",  {31'd0, w_full_a},  {31'd0, (q_a.size() > 60)});
    chk("a_r_empty", {31'd0, r_empty_a}, {31'd0, (q_a.size() < 1)});
  endtask

  task automatic step_b(input logic we, input logic [7:0] wd, input logic re, input logic exp_ren);
    @(negedge clk);
    w_en_b = we; w_data_b = wd; r_en_b = re;
    #1;
    chk("b_mem_r_en", {31'd0, mr_en_b}, {31'd0, exp_ren});
    @(posedge clk);
    #1;
    @(negedge clk);
    w_en_b = 1'b0; r_en_b = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    w_en_a = 1'b0; r_en_a = 1'b0; w_en_b = 1'b0; r_en_b = 1'b0;
    rst_n = 1'b0;
    #2;
    chk({tag, "_level"},   {25'd0, level_a},   32'd0);
    chk({tag, "_r_empty"}, {31'd0, r_empty_a}, 32'd1);
    chk({tag, "_w_full"},  {31'd0, w_full_a},  32'd0);
    chk({tag, "_w_en"},    {31'd0, mw_en_a},   32'd0);
    chk({tag, "_b_level"}, {25'd0, level_b},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q_a.delete();
    wptr_m = 0; rptr_m = 0; last_rd_m = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    w_en_a = 1'b0; r_en_a = 1'b0; w_data_a = '0;
    w_en_b = 1'b0; r_en_b = 1'b0; w_data_b = '0;
    wptr_m = 0; rptr_m = 0; last_rd_m = '0;
    repeat (2) @(posedge clk);

    // 1. reset state
    pulse_reset("rst");
    step_a(1'b0, 32'd0, 1'b0);

    // 2. one wide write, four narrow reads, little-endian order
    step_a(1'b1, 32'h44332211, 1'b0);
    chk("t2_level_after_write", {25'd0, level_a}, 32'd4);
    step_a(1'b0, 32'd0, 1'b1);
    chk("t2_rd0", {24'd0, r_data_a}, 32'h11);
    step_a(1'b0, 32'd0, 1'b1);
    chk("t2_rd1", {24'd0, r_data_a}, 32'h22);
    step_a(1'b0, 32'd0, 1'b1);
    chk("t2_rd2", {24'd0, r_data_a}, 32'h33);
    step_a(1'b0, 32'd0, 1'b1);
    chk("t2_rd3", {24'd0, r_data_a}, 32'h44);
    chk("t2_level0", {25'd0, level_a}, 32'd0);
    chk("t2_empty", {31'd0, r_empty_a}, 32'd1);

    // 4. read while empty: no enable, data held
    step_a(1'b0, 32'd0, 1'b1);
    chk("t4_rdata_hold", {24'd0, r_data_a}, 32'h44);

    // 3. fill to full, then a dropped write
    for (int i = 0; i < 16; i++) step_a(1'b1, 32'hA0B0C0D0 + i, 1'b0);
    chk("t3_level_full", {25'd0, level_a}, 32'd64);
    chk("t3_w_full", {31'd0, w_full_a}, 32'd1);
    step_a(1'b1, 32'hDEADBEEF, 1'b0);
    chk("t3_level_stuck", {25'd0, level_a}, 32'd64);

    // 5. drain to 4, then simultaneous write and read
    for (int i = 0; i < 60; i++) step_a(1'b0, 32'd0, 1'b1);
    chk("t5_level4", {25'd0, level_a}, 32'd4);
    step_a(1'b1, 32'h87654321, 1'b1);
    chk("t5_level7", {25'd0, level_a}, 32'd7);
    for (int i = 0; i < 7; i++) step_a(1'b0, 32'd0, 1'b1);
    chk("t5_last_byte", {24'd0, r_data_a}, 32'h87);

    // 6. random streaming with a reset in the middle
    for (int i = 0; i < 700; i++) begin
      int pw, pr;
      pw = (i < 150) ? 70 : (i < 250) ? 20 : 50;
      pr = (i < 150) ? 40 : (i < 250) ? 80 : 55;
      if (i == 350) pulse_reset("mid");
      step_a(($urandom_range(0, 99) < pw), $urandom, ($urandom_range(0, 99) < pr));
    end
    for (int i = 0; i < 70; i++) step_a(1'b0, 32'd0, 1'b1);
    chk("t6_drained", {31'd0, r_empty_a}, 32'd1);

    // 6b. narrow write, wide read
    pulse_reset("b");
    step_b(1'b1, 8'hA1, 1'b0, 1'b0);
    step_b(1'b1, 8'hB2, 1'b0, 1'b0);
    step_b(1'b1, 8'hC3, 1'b1, 1'b0);
    chk("b_empty_after3", {31'd0, r_empty_b}, 32'd1);
    chk("b_level3", {25'd0, level_b}, 32'd3);
    step_b(1'b1, 8'hD4, 1'b0, 1'b0);
    chk("b_empty_after4", {31'd0, r_empty_b}, 32'd0);
    chk("b_level4", {25'd0, level_b}, 32'd4);
    @(negedge clk);
    r_en_b = 1'b1;
    #1;
    chk("b_mem_r_en_go", {31'd0, mr_en_b}, 32'd1);
    @(posedge clk);
    #1;
    r_en_b = 1'b0;
    chk("b_r_data", r_data_b, 32'hD4C3B2A1);
    chk("b_level0", {25'd0, level_b}, 32'd0);
    chk("b_empty_end", {31'd0, r_empty_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
